// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   arb_state_t : arbitration priority state (CPU-first or forced DMA turn)
//   rd_owner_t  : which requester owns the read data returning next cycle
package mem_arb_pkg;

   typedef enum logic {
      PRI_CPU = 1'b0,
      PRI_DMA = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous data memory between the pipeline MEM
// stage (CPU) and the DMA/loader engine.
//
// The CPU wins contested cycles by default. After STARVE_LIMIT consecutive
// DMA losses, the DMA gets exactly one forced grant. Read data comes back one
// cycle after the grant and goes only to the requester that issued the read.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   cpu_req/we/addr/wdata           CPU request side
//   cpu_rdata, cpu_rvalid           CPU read return
//   cpu_stall                       CPU request not granted this cycle
//   dma_req/we/addr/wdata           DMA request side
//   dma_gnt                         DMA request accepted this cycle
//   dma_rdata, dma_rvalid           DMA read return
//   mem_en/we/addr/wdata            memory command (combinational from winner)
//   mem_rdata                       memory read data (cycle after read)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ARQ              = 16,
   parameter int MEMORY_ADDR_SIZE = 13,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_req,
   input  logic                        cpu_we,
   input  logic [MEMORY_ADDR_SIZE-1:0] cpu_addr,
   input  logic [ARQ-1:0]              cpu_wdata,
   output logic [ARQ-1:0]              cpu_rdata,
   output logic                        cpu_rvalid,
   output logic                        cpu_stall,
   input  logic                        dma_req,
   input  logic                        dma_we,
   input  logic [MEMORY_ADDR_SIZE-1:0] dma_addr,
   input  logic [ARQ-1:0]              dma_wdata,
   output logic                        dma_gnt,
   output logic [ARQ-1:0]              dma_rdata,
   output logic                        dma_rvalid,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
   output logic [ARQ-1:0]              mem_wdata,
   input  logic [ARQ-1:0]              mem_rdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   arb_state_t state_r;
   arb_state_t state_nxt_s;
   logic [3:0] starve_cnt_r;
   logic [3:0] starve_cnt_nxt_s;
   rd_owner_t  rd_owner_r;
   rd_owner_t  rd_owner_nxt_s;
   logic [ARQ-1:0] cpu_hold_r;
   logic [ARQ-1:0] dma_hold_r;

   logic cpu_win_s;
   logic dma_win_s;

   // Winner selection; both grants are suppressed while reset is asserted.
   always_comb begin
      cpu_win_s = 1'b0;
      dma_win_s = 1'b0;
      if (rst) begin
         cpu_win_s = 1'b0;
         dma_win_s = 1'b0;
      end else begin
         // DMA wins when uncontested, or when it holds the forced turn.
         if (dma_req && (!cpu_req || (state_r == PRI_DMA))) begin
            dma_win_s = 1'b1;
         end else begin
            dma_win_s = 1'b0;
         end
         cpu_win_s = cpu_req & ~dma_win_s;
      end
   end

   // Handshake outputs.
   always_comb begin
      cpu_stall = cpu_req & ~cpu_win_s & ~rst;
      dma_gnt   = dma_req & dma_win_s;
   end

   // Memory command mux; idle cycles drive an all-zero command.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_win_s) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_win_s) begin
         mem_en    = 1'b1;
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Priority FSM and starvation counter next-state.
   always_comb begin
      state_nxt_s      = state_r;
      starve_cnt_nxt_s = starve_cnt_r;
      case (state_r)
         PRI_CPU: begin
            if (dma_win_s) begin
               starve_cnt_nxt_s = 4'd0;
            end else if (dma_req) begin
               if ((starve_cnt_r + 4'd1) == STARVE_LIM) begin
                  state_nxt_s      = PRI_DMA;
                  starve_cnt_nxt_s = 4'd0;
               end else begin
                  starve_cnt_nxt_s = starve_cnt_r + 4'd1;
               end
            end else begin
               starve_cnt_nxt_s = starve_cnt_r;
            end
         end
         PRI_DMA: begin
            // A present dma_req always wins here, so the forced turn is
            // consumed in one cycle; a dropped request also ends it.
            state_nxt_s      = PRI_CPU;
            starve_cnt_nxt_s = 4'd0;
         end
         default: begin
            state_nxt_s      = PRI_CPU;
            starve_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // Records who receives the read data returning next cycle.
   always_comb begin
      rd_owner_nxt_s = OWN_NONE;
      if (cpu_win_s && !cpu_we) begin
         rd_owner_nxt_s = OWN_CPU;
      end else if (dma_win_s && !dma_we) begin
         rd_owner_nxt_s = OWN_DMA;
      end else begin
         rd_owner_nxt_s = OWN_NONE;
      end
   end

   // State, counter and read-owner registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= PRI_CPU;
         starve_cnt_r <= 4'd0;
         rd_owner_r   <= OWN_NONE;
      end else begin
         state_r      <= state_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
         rd_owner_r   <= rd_owner_nxt_s;
      end
   end

   // Per-requester hold of the last delivered read word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_hold_r <= '0;
         dma_hold_r <= '0;
      end else begin
         if (rd_owner_r == OWN_CPU) begin
            cpu_hold_r <= mem_rdata;
         end
         if (rd_owner_r == OWN_DMA) begin
            dma_hold_r <= mem_rdata;
         end
      end
   end

   // Read return: the owner sees live memory data, the other keeps its hold.
   always_comb begin
      cpu_rvalid = (rd_owner_r == OWN_CPU);
      dma_rvalid = (rd_owner_r == OWN_DMA);
      if (rd_owner_r == OWN_CPU) begin
         cpu_rdata = mem_rdata;
      end else begin
         cpu_rdata = cpu_hold_r;
      end
      if (rd_owner_r == OWN_DMA) begin
         dma_rdata = mem_rdata;
      end else begin
         dma_rdata = dma_hold_r;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// synchronous RAM attached to the memory port.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [12:0] cpu_addr, dma_addr, mem_addr;
   logic [15:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
   logic [15:0] cpu_rdata, dma_rdata;
   logic        cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we;

   int total;
   int bad;

   logic [15:0] ram [0:8191];

   mem_port_arbiter #(.ARQ(16), .MEMORY_ADDR_SIZE(13), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM model
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // Drive one cycle of requests at the falling edge, then let logic settle.
   task automatic drive(input logic cr, input logic cw, input logic [12:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic [12:0] da, input logic [15:0] dd);
      @(negedge clk);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0AAA; cpu_wdata = 16'h5555;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h0BBB; dma_wdata = 16'h6666;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({cpu_rvalid, dma_rvalid, dma_gnt, cpu_stall, mem_en, mem_we} !== 6'b000000) begin
         bad++; $display("FAIL reset_ctrl got=%b want=000000", {cpu_rvalid, dma_rvalid, dma_gnt, cpu_stall, mem_en, mem_we});
      end
      total++;
      if ({cpu_rdata, dma_rdata} !== 32'h0) begin
         bad++; $display("FAIL reset_rdata got=%h want=0", {cpu_rdata, dma_rdata});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({cpu_stall, dma_gnt, mem_en} !== 3'b001 || mem_addr !== 13'h0AAA) begin
         bad++; $display("FAIL reset_first_win got stall/gnt/en=%b addr=%h want=001 addr=0aaa", {cpu_stall, dma_gnt, mem_en}, mem_addr);
      end
      do_reset();
   endtask

   task automatic test_cpu_only();
      drive(1'b1, 1'b1, 13'h0011, 16'h1234, 1'b0, 1'b0, 13'h0000, 16'h0000);
      total++;
      if ({mem_en, mem_we, cpu_stall} !== 3'b110 || mem_addr !== 13'h0011 || mem_wdata !== 16'h1234) begin
         bad++; $display("FAIL cpu_write got en/we/stall=%b addr=%h data=%h want=110 0011 1234", {mem_en, mem_we, cpu_stall}, mem_addr, mem_wdata);
      end
      drive(1'b1, 1'b0, 13'h0011, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
      total++;
      if ({mem_en, mem_we, cpu_stall, cpu_rvalid} !== 4'b1000 || mem_addr !== 13'h0011) begin
         bad++; $display("FAIL cpu_read_cmd got en/we/stall/rv=%b addr=%h want=1000 0011", {mem_en, mem_we, cpu_stall, cpu_rvalid}, mem_addr);
      end
      idle();
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234 || dma_rvalid !== 1'b0) begin
         bad++; $display("FAIL cpu_read_ret got rv=%b data=%h dma_rv=%b want 1 1234 0", cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      total++;
      if (mem_en !== 1'b0 || mem_addr !== 13'h0 || mem_wdata !== 16'h0 || mem_we !== 1'b0) begin
         bad++; $display("FAIL idle_cmd got en=%b we=%b addr=%h data=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_starvation();
      logic want_dma;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b1, 13'h0020, 16'h00C0, 1'b1, 1'b1, 13'h0030, 16'h00D0);
         want_dma = ((k % 5) == 4);
         total++;
         if (dma_gnt !== want_dma || cpu_stall !== want_dma) begin
            bad++; $display("FAIL starve_cyc%0d got gnt=%b stall=%b want=%b", k, dma_gnt, cpu_stall, want_dma);
         end
         total++;
         if (mem_addr !== (want_dma ? 13'h0030 : 13'h0020)) begin
            bad++; $display("FAIL starve_addr%0d got=%h want=%h", k, mem_addr, want_dma ? 13'h0030 : 13'h0020);
         end
      end
   endtask

   task automatic test_interleaved();
      drive(1'b1, 1'b1, 13'h0100, 16'hA1A1, 1'b0, 1'b0, 13'h0000, 16'h0000);
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b1, 13'h0200, 16'hB2B2);
      drive(1'b1, 1'b0, 13'h0100, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
      total++;
      if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
         bad++; $display("FAIL ilv_n got stall=%b crv=%b drv=%b want 000", cpu_stall, cpu_rvalid, dma_rvalid);
      end
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 13'h0200, 16'h0000);
      total++;
      if (dma_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA1A1 || dma_rvalid !== 1'b0) begin
         bad++; $display("FAIL ilv_n1 got gnt=%b crv=%b cdata=%h drv=%b want 1 1 a1a1 0", dma_gnt, cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      idle();
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hB2B2 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hA1A1) begin
         bad++; $display("FAIL ilv_n2 got drv=%b ddata=%h crv=%b cdata=%h want 1 b2b2 0 a1a1", dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 1'b1, 13'h0040, 16'h0001, 1'b1, 1'b1, 13'h0041, 16'h0002);
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 13'h0200, 16'h0000);
      total++;
      if (dma_gnt !== 1'b1) begin
         bad++; $display("FAIL mid_grant got=%b want=1", dma_gnt);
      end
      @(negedge clk);
      rst = 1'b1;
      cpu_req = 1'b0; dma_req = 1'b0;
      #1;
      total++;
      if (dma_rvalid !== 1'b0 || dma_rdata !== 16'h0) begin
         bad++; $display("FAIL mid_in_rst got rv=%b data=%h want 0 0000", dma_rvalid, dma_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (dma_rvalid !== 1'b0 || dut.starve_cnt_r !== 4'd0 || dut.state_r !== PRI_CPU) begin
         bad++; $display("FAIL mid_after got rv=%b cnt=%0d st=%b want 0 0 0", dma_rvalid, dut.starve_cnt_r, dut.state_r);
      end
      idle();
      total++;
      if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
         bad++; $display("FAIL mid_later got drv=%b crv=%b want 0 0", dma_rvalid, cpu_rvalid);
      end
   endtask

   task automatic test_dma_drop();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 13'h0050, 16'h0000, 1'b1, 1'b1, 13'h0060, 16'h0000);
         total++;
         if (cpu_stall !== 1'b0) begin
            bad++; $display("FAIL drop_pre%0d stall got=%b want=0", k, cpu_stall);
         end
      end
      drive(1'b1, 1'b1, 13'h0055, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
      total++;
      if (dut.state_r !== PRI_DMA || cpu_stall !== 1'b0 || dma_gnt !== 1'b0 || mem_addr !== 13'h0055) begin
         bad++; $display("FAIL drop_cyc got st=%b stall=%b gnt=%b addr=%h want 1 0 0 0055", dut.state_r, cpu_stall, dma_gnt, mem_addr);
      end
      drive(1'b1, 1'b1, 13'h0056, 16'h0000, 1'b1, 1'b1, 13'h0060, 16'h0000);
      total++;
      if (dut.state_r !== PRI_CPU || cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
         bad++; $display("FAIL drop_back got st=%b stall=%b gnt=%b want 0 0 0", dut.state_r, cpu_stall, dma_gnt);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 1'b1, 13'h0300, 16'h1111, 1'b0, 1'b0, 13'h0000, 16'h0000);
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b1, 13'h0301, 16'h2222);
      drive(1'b1, 1'b1, 13'h1FFF, 16'h3333, 1'b0, 1'b0, 13'h0000, 16'h0000);
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b1, 13'h0000, 16'h4444);
      drive(1'b1, 1'b0, 13'h0300, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 13'h0301, 16'h0000);
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1111 || dma_rvalid !== 1'b0) begin
         bad++; $display("FAIL b2b_0 got crv=%b cdata=%h drv=%b want 1 1111 0", cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      drive(1'b1, 1'b0, 13'h1FFF, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000);
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 16'h2222 || cpu_rvalid !== 1'b0 || mem_addr !== 13'h1FFF) begin
         bad++; $display("FAIL b2b_1 got drv=%b ddata=%h crv=%b addr=%h want 1 2222 0 1fff", dma_rvalid, dma_rdata, cpu_rvalid, mem_addr);
      end
      drive(1'b0, 1'b0, 13'h0000, 16'h0000, 1'b1, 1'b0, 13'h0000, 16'h0000);
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h3333 || dma_rvalid !== 1'b0 || dma_rdata !== 16'h2222) begin
         bad++; $display("FAIL b2b_2 got crv=%b cdata=%h drv=%b ddata=%h want 1 3333 0 2222", cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata);
      end
      idle();
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 16'h4444 || cpu_rvalid !== 1'b0) begin
         bad++; $display("FAIL b2b_3 got drv=%b ddata=%h crv=%b want 1 4444 0", dma_rvalid, dma_rdata, cpu_rvalid);
      end
      idle();
      total++;
      if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== 16'h3333 || dma_rdata !== 16'h4444) begin
         bad++; $display("FAIL b2b_hold got crv=%b drv=%b cdata=%h ddata=%h want 0 0 3333 4444", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_cpu_only();
      test_starvation();
      test_interleaved();
      test_reset_mid();
      test_dma_drop();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
